// File: rtl/mux_serial_nx1.sv
// Serializes LANES parallel input lanes onto one WIDTH-bit output, one slot per clk_4f cycle.
// Optionally compacts the valid lanes to the front of each frame.
module mux_serial_nx1 #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned SKIP_INVALID = 0
) (
  input  logic                       clk_4f,
  input  logic                       reset,
  input  logic [WIDTH*LANES-1:0]     Entrada,
  input  logic [LANES-1:0]           validEntrada,
  output logic [WIDTH-1:0]           Salida,
  output logic                       validsalida,
  output logic [$clog2(LANES)-1:0]   lane_sel,
  output logic                       frame_start
);

  localparam int unsigned SEL_W = $clog2(LANES);
  localparam int unsigned SP_W  = SEL_W + 1;

  logic [SEL_W-1:0] cnt;
  logic [SP_W-1:0]  sp;
  logic [WIDTH-1:0] shadow_data [LANES];
  logic [LANES-1:0] shadow_valid;

  logic [SP_W-1:0]  start_sp;
  logic             found;
  logic [SEL_W-1:0] pick;
  logic [SP_W-1:0]  nxt_sp;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_valid;
  logic [WIDTH-1:0] nxt_data;

  // Slot selection from the shadow bank; the search restarts at lane 0 on slot 0.
  always_comb begin
    start_sp  = (cnt == '0) ? '0 : sp;
    found     = 1'b0;
    pick      = '0;
    nxt_sp    = '0;
    nxt_sel   = cnt;
    nxt_valid = 1'b0;
    for (int j = 0; j < int'(LANES); j++) begin
      if (!found && (SP_W'(j) >= start_sp) && shadow_valid[j]) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
    if (SKIP_INVALID != 0) begin
      nxt_valid = found;
      nxt_sel   = found ? pick : cnt;
      nxt_sp    = found ? (SP_W'(pick) + SP_W'(1)) : SP_W'(LANES);
    end else begin
      nxt_valid = shadow_valid[cnt];
      nxt_sel   = cnt;
    end
    nxt_data = nxt_valid ? shadow_data[nxt_sel] : '0;
  end

  // Slot counter, search pointer, shadow bank and registered outputs.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      cnt          <= '0;
      sp           <= '0;
      shadow_valid <= '0;
      for (int i = 0; i < int'(LANES); i++) shadow_data[i] <= '0;
      Salida       <= '0;
      validsalida  <= 1'b0;
      lane_sel     <= '0;
      frame_start  <= 1'b0;
    end else begin
      cnt         <= cnt + SEL_W'(1);
      sp          <= nxt_sp;
      Salida      <= nxt_data;
      validsalida <= nxt_valid;
      lane_sel    <= nxt_sel;
      frame_start <= (cnt == '0);
      // Capture the next frame on the last slot; the current frame reads the old bank.
      if (cnt == SEL_W'(LANES - 1)) begin
        shadow_valid <= validEntrada;
        for (int i = 0; i < int'(LANES); i++) shadow_data[i] <= Entrada[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: doc/mux_serial_nx1.md
MUX_SERIAL_NX1 -- requirements
Module: mux_serial_nx1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: lane data width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter LANES, default 4: number of input lanes, a power of two in 2..16.
REQ-003 The block SHALL have parameter SKIP_INVALID, default 0: 0 = fixed slot mapping, 1 = compact valid lanes to the front of the frame.
REQ-004 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low; reset=0 at a rising edge of clk_4f resets the block.
REQ-006 The block SHALL have port Entrada, input, WIDTH*LANES bits: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port validEntrada, input, LANES bits: bit i qualifies lane i.
REQ-008 The block SHALL have port Salida, output, WIDTH bits: serialized data, registered.
REQ-009 The block SHALL have port validsalida, output, 1 bit: qualifies Salida, registered.
REQ-010 The block SHALL have port lane_sel, output, log2(LANES) bits: source lane of the current Salida, registered.
REQ-011 The block SHALL have port frame_start, output, 1 bit: high while the output register holds frame slot 0.

Function
REQ-012 The block SHALL keep a slot counter cnt (log2(LANES) bits) that increments by 1 every clk_4f cycle out of reset, wrapping LANES-1 -> 0.
REQ-013 The block SHALL load all lanes of Entrada and validEntrada into a shadow bank on each edge where cnt==LANES-1; the shadow bank holds its value on all other edges.
REQ-014 The block SHALL use each edge where cnt==c to load the output registers with frame slot c, read from the shadow bank contents present before that edge (old frame at the load edge).
REQ-015 The block SHALL, with SKIP_INVALID=0, emit on slot c: Salida=shadow lane c data, validsalida=shadow valid c, lane_sel=c.
REQ-016 The block SHALL, with SKIP_INVALID=1, maintain a search pointer sp: sp=0 at slot 0; each slot selects the lowest lane j>=sp with shadow valid j=1, emits it with validsalida=1 and lane_sel=j, then sets sp=j+1.
REQ-017 The block SHALL, with SKIP_INVALID=1, emit validsalida=0 on any slot where no such lane j exists (remaining slots of the frame), with lane_sel=c.
REQ-018 The block SHALL drive Salida to all zeros whenever it drives validsalida=0, in both modes.
REQ-019 The block SHALL assert frame_start exactly on cycles where the output register holds slot 0, independent of validity.
REQ-020 Latency: a lane sampled at load edge E SHALL appear at the output after edge E+1+slot, where slot is the frame slot it occupies.
REQ-021 The block SHALL handle all-lanes-invalid by producing a full frame of validsalida=0 and Salida=0 in both modes.
REQ-022 The block SHALL handle all-lanes-valid identically in both modes (lane i on slot i).
REQ-023 Input changes on edges where cnt!=LANES-1 SHALL have no effect on the output.

Reset
REQ-024 On an edge with reset=0, the block SHALL set cnt=0, sp=0, shadow data=0, shadow valid=0, Salida=0, validsalida=0, lane_sel=0, and frame_start=0.
REQ-025 The first edge with reset=1 SHALL be treated as cnt==0, emitting slot 0 of the cleared shadow bank; this makes the first frame after reset all-invalid with frame_start=1 on its first output cycle.
REQ-026 Reset asserted mid-frame SHALL abort the frame: no partial-frame data appears after release.

Verification (WIDTH=8, LANES=4)
REQ-027 The bench SHALL cover this reset case: hold reset=0 for 3 cycles, then release -> outputs 0 during reset; first frame after release has 4 slots with validsalida=0, Salida=0x00, lane_sel=0,1,2,3, and frame_start=1 on slot 0 only.
REQ-028 The bench SHALL cover mode 0 full: Entrada={0x44,0x33,0x22,0x11} (lane3..lane0), validEntrada=4'b1111 held -> repeating frames Salida=0x11,0x22,0x33,0x44 with validsalida=1 and lane_sel=0..3.
REQ-029 The bench SHALL cover mode 0 sparse: validEntrada=4'b1010 with the same data -> slots emit 0x00/v0, 0x22/v1, 0x00/v0, 0x44/v1.
REQ-030 The bench SHALL cover mode 1 sparse: validEntrada=4'b1010 -> slot0 0x22 lane_sel=1, slot1 0x44 lane_sel=3, slots 2-3 validsalida=0 and Salida=0x00.
REQ-031 The bench SHALL cover input timing: change Entrada lane0 to 0xAA on a cycle where cnt==1 and revert it before cnt==3 -> 0xAA never appears on Salida; change it and hold through the cnt==3 edge -> 0xAA appears on the next slot 0.
REQ-032 The bench SHALL cover reset mid-frame: assert reset=0 during slot 2 of a valid frame -> Salida=0 and validsalida=0 on the next edge; after release, one all-invalid frame is emitted, then fresh data.
